// File: rtl/axi_tdd_ng_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_tdd_ng_sync_gen
// Brief    : Merges external, internal periodic and software sync sources into
//            a single-cycle tdd_sync pulse, a stretched sync_out and a counter.
// Revision : 1.0 - initial release
// ============================================================================
module axi_tdd_ng_sync_gen #(
  parameter int SYNC_COUNT_WIDTH  = 64,
  parameter int SYNC_EXTERNAL_CDC = 1,
  parameter int SYNC_OUT_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        sync_in,
  input  logic                        tdd_enable,
  input  logic                        tdd_sync_ext,
  input  logic                        tdd_sync_int,
  input  logic                        tdd_sync_soft,
  input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_period,
  output logic                        tdd_sync,
  output logic                        sync_out,
  output logic [31:0]                 tdd_sync_count
);

  localparam int STR_W = (SYNC_OUT_WIDTH > 1) ? $clog2(SYNC_OUT_WIDTH) : 1;
  localparam logic [SYNC_COUNT_WIDTH-1:0] c_cnt_one  = SYNC_COUNT_WIDTH'(1);
  localparam logic [STR_W-1:0]            c_str_load = STR_W'(SYNC_OUT_WIDTH - 1);
  localparam logic [STR_W-1:0]            c_str_one  = STR_W'(1);

  logic                        w_ext_rise;
  logic                        w_ext_evt;
  logic                        w_soft_evt;
  logic                        w_int_run;
  logic                        w_int_evt;
  logic                        r_soft_ff1;
  logic                        r_soft_ff2;
  logic [SYNC_COUNT_WIDTH-1:0] r_int_cnt;
  logic [STR_W-1:0]            r_str_cnt;

  // Synchronizer and edge history run regardless of enable, so a level that
  // is already high when the source gets enabled never looks like an edge.
  generate
    if (SYNC_EXTERNAL_CDC != 0) begin : g_ext_cdc
      logic r_ff1, r_ff2, r_ff3;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_ff1 <= 1'b0;
          r_ff2 <= 1'b0;
          r_ff3 <= 1'b0;
        end else begin
          r_ff1 <= sync_in;
          r_ff2 <= r_ff1;
          r_ff3 <= r_ff2;
        end
      end
      assign w_ext_rise = r_ff2 & ~r_ff3;
    end else begin : g_ext_direct
      logic r_ff1, r_ff2;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_ff1 <= 1'b0;
          r_ff2 <= 1'b0;
        end else begin
          r_ff1 <= sync_in;
          r_ff2 <= r_ff1;
        end
      end
      assign w_ext_rise = r_ff1 & ~r_ff2;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_soft_ff1 <= 1'b0;
      r_soft_ff2 <= 1'b0;
    end else begin
      r_soft_ff1 <= tdd_sync_soft;
      r_soft_ff2 <= r_soft_ff1;
    end
  end

  assign w_ext_evt  = w_ext_rise & tdd_sync_ext & tdd_enable;
  assign w_soft_evt = r_soft_ff1 & ~r_soft_ff2 & tdd_enable;
  assign w_int_run  = tdd_enable & tdd_sync_int & (|tdd_sync_period);
  // >= lets a period shrunk below the running count fire and wrap at once.
  assign w_int_evt  = w_int_run & (r_int_cnt >= (tdd_sync_period - c_cnt_one));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_int_cnt <= '0;
    end else if (!w_int_run || w_int_evt || w_ext_evt || w_soft_evt) begin
      r_int_cnt <= '0;
    end else begin
      r_int_cnt <= r_int_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdd_sync       <= 1'b0;
      tdd_sync_count <= 32'd0;
    end else if (!tdd_enable) begin
      tdd_sync       <= 1'b0;
      tdd_sync_count <= 32'd0;
    end else begin
      tdd_sync <= w_ext_evt | w_soft_evt | w_int_evt;
      if (tdd_sync) begin
        tdd_sync_count <= tdd_sync_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_str_cnt <= '0;
      sync_out  <= 1'b0;
    end else if (!tdd_enable) begin
      r_str_cnt <= '0;
      sync_out  <= 1'b0;
    end else if (tdd_sync) begin
      r_str_cnt <= c_str_load;
      sync_out  <= 1'b1;
    end else if (r_str_cnt != '0) begin
      r_str_cnt <= r_str_cnt - c_str_one;
      sync_out  <= 1'b1;
    end else begin
      sync_out  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
